// File: rtl/p405s_icu_parity_array.sv
// rtl/p405s_icu_parity_array.sv - ICU array with march-test BIST and write capture
//
// Purpose: DEPTH x DATA_W storage array with a functional port, a built-in
// march test (W0, R0W1, R1W0, R0) that takes over the array while running,
// and a shadow capture of every write that reaches the array.
//
// Ports:
//   cclk, rst_n                  clock, asynchronous active-low reset
//   func_cen, func_wen           functional chip enable / per-bit write enable (active-low)
//   func_addr, func_din          functional address / write data
//   func_dout                    registered read data (write-through)
//   bist_start                   single-cycle BIST request
//   bist_busy, bist_done         BIST owns array / sticky test-finished
//   bist_fail, bist_fail_addr    sticky miscompare flag / first failing address
//   cap_mem_we/addr/wr_data      one-cycle shadow of each post-mux write

module p405s_icu_parity_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              cclk,
  input  logic              rst_n,
  input  logic              func_cen,
  input  logic [DATA_W-1:0] func_wen,
  input  logic [ADDR_W-1:0] func_addr,
  input  logic [DATA_W-1:0] func_din,
  output logic [DATA_W-1:0] func_dout,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic              cap_mem_we,
  output logic [ADDR_W-1:0] cap_mem_addr,
  output logic [DATA_W-1:0] cap_mem_wr_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_W0, S_R0W1, S_R1W0, S_R0, S_DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] b_addr;
  logic              phase;      // R0W1/R1W0: 0 = read half, 1 = write half

  // BIST-side array controls
  logic              b_cen;
  logic [DATA_W-1:0] b_wen;
  logic [DATA_W-1:0] b_din;
  logic              b_read;

  // Post-mux array controls
  logic              m_cen;
  logic [DATA_W-1:0] m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;
  logic              m_write;
  logic [DATA_W-1:0] wr_word;

  // Compare pipeline: data read by BIST is checked in the following cycle
  logic              cmp_valid;
  logic              cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] bist_rd;
  logic              cmp_miss;

  always_comb begin
    b_cen = 1'b1;
    b_wen = ONES;
    b_din = '0;
    case (state)
      S_W0:   begin b_cen = 1'b0; b_wen = '0; end
      S_R0W1: begin
        b_cen = 1'b0;
        if (phase) begin b_wen = '0; b_din = ONES; end
      end
      S_R1W0: begin
        b_cen = 1'b0;
        if (phase) b_wen = '0;
      end
      S_R0:   b_cen = 1'b0;
      default: ;
    endcase
  end

  // b_cen is only low in active march states, so a low b_cen implies BIST owns the port
  assign b_read = !b_cen && (b_wen == ONES);

  always_comb begin
    m_cen   = bist_busy ? b_cen  : func_cen;
    m_wen   = bist_busy ? b_wen  : func_wen;
    m_addr  = bist_busy ? b_addr : func_addr;
    m_din   = bist_busy ? b_din  : func_din;
    m_write = !m_cen && (m_wen != ONES);
    // Merged word: written bits take new data, others keep stored data
    wr_word = (mem[m_addr] & m_wen) | (m_din & ~m_wen);
  end

  always_ff @(posedge cclk) begin
    if (m_write) mem[m_addr] <= wr_word;
  end

  assign cmp_miss = cmp_valid && (bist_rd != {DATA_W{cmp_exp}});

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      b_addr          <= '0;
      phase           <= 1'b0;
      bist_busy       <= 1'b0;
      bist_done       <= 1'b0;
      bist_fail       <= 1'b0;
      bist_fail_addr  <= '0;
      func_dout       <= '0;
      cap_mem_we      <= 1'b0;
      cap_mem_addr    <= '0;
      cap_mem_wr_data <= '0;
      cmp_valid       <= 1'b0;
      cmp_exp         <= 1'b0;
      cmp_addr        <= '0;
      bist_rd         <= '0;
    end else begin
      if (!bist_busy && !func_cen) func_dout <= wr_word;

      cap_mem_we <= m_write;
      if (m_write) begin
        cap_mem_addr    <= m_addr;
        cap_mem_wr_data <= m_din;
      end

      cmp_valid <= b_read;
      if (b_read) begin
        cmp_exp  <= (state == S_R1W0);
        cmp_addr <= b_addr;
        bist_rd  <= wr_word;
      end

      if (cmp_miss) begin
        bist_fail <= 1'b1;
        if (!bist_fail) bist_fail_addr <= cmp_addr;
      end

      case (state)
        S_IDLE: begin
          if (bist_start) begin
            state          <= S_W0;
            bist_busy      <= 1'b1;
            bist_done      <= 1'b0;
            bist_fail      <= 1'b0;
            bist_fail_addr <= '0;
            b_addr         <= '0;
            phase          <= 1'b0;
          end
        end
        S_W0: begin
          if (b_addr == ADDR_MAX) begin
            state  <= S_R0W1;
            b_addr <= '0;
          end else begin
            b_addr <= b_addr + ADDR_W'(1);
          end
        end
        S_R0W1: begin
          phase <= !phase;
          if (phase) begin
            if (b_addr == ADDR_MAX) begin
              state  <= S_R1W0;
              b_addr <= ADDR_MAX;
            end else begin
              b_addr <= b_addr + ADDR_W'(1);
            end
          end
        end
        S_R1W0: begin
          phase <= !phase;
          if (phase) begin
            if (b_addr == '0) begin
              state  <= S_R0;
              b_addr <= '0;
            end else begin
              b_addr <= b_addr - ADDR_W'(1);
            end
          end
        end
        S_R0: begin
          if (b_addr == ADDR_MAX) state <= S_DONE;
          else                    b_addr <= b_addr + ADDR_W'(1);
        end
        // DONE is the cycle of the final compare; busy drops as it is left
        S_DONE: begin
          state     <= S_IDLE;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p405s_icu_parity_array.sv
// tb/tb_p405s_icu_parity_array.sv - self-checking bench for p405s_icu_parity_array

module tb_p405s_icu_parity_array;

  logic        cclk = 1'b0;
  always #5 cclk = ~cclk;

  logic        rst_n;
  logic        func_cen;
  logic [7:0]  func_wen;
  logic [8:0]  func_addr;
  logic [7:0]  func_din;
  logic [7:0]  func_dout;
  logic        bist_start;
  logic        bist_busy, bist_done, bist_fail;
  logic [8:0]  bist_fail_addr;
  logic        cap_mem_we;
  logic [8:0]  cap_mem_addr;
  logic [7:0]  cap_mem_wr_data;

  logic        func_cen2;
  logic [15:0] func_wen2;
  logic [3:0]  func_addr2;
  logic [15:0] func_din2;
  logic [15:0] func_dout2;
  logic        bist_start2;
  logic        bist_busy2, bist_done2, bist_fail2;
  logic [3:0]  bist_fail_addr2;
  logic        cap_mem_we2;
  logic [3:0]  cap_mem_addr2;
  logic [15:0] cap_mem_wr_data2;

  p405s_icu_parity_array dut (
    .cclk(cclk), .rst_n(rst_n),
    .func_cen(func_cen), .func_wen(func_wen), .func_addr(func_addr), .func_din(func_din),
    .func_dout(func_dout), .bist_start(bist_start), .bist_busy(bist_busy),
    .bist_done(bist_done), .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr),
    .cap_mem_we(cap_mem_we), .cap_mem_addr(cap_mem_addr), .cap_mem_wr_data(cap_mem_wr_data)
  );

  p405s_icu_parity_array #(.DATA_W(16), .ADDR_W(4)) dut2 (
    .cclk(cclk), .rst_n(rst_n),
    .func_cen(func_cen2), .func_wen(func_wen2), .func_addr(func_addr2), .func_din(func_din2),
    .func_dout(func_dout2), .bist_start(bist_start2), .bist_busy(bist_busy2),
    .bist_done(bist_done2), .bist_fail(bist_fail2), .bist_fail_addr(bist_fail_addr2),
    .cap_mem_we(cap_mem_we2), .cap_mem_addr(cap_mem_addr2), .cap_mem_wr_data(cap_mem_wr_data2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: array contents and which words are fully known
  logic [7:0] model [512];
  bit         known [512];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 512; i++) begin
      model[i] = 8'h00;
      known[i] = 1'b1;
    end
  endtask

  task automatic func_access(input logic [8:0] a, input logic [7:0] wen, input logic [7:0] din);
    func_cen  = 1'b0;
    func_wen  = wen;
    func_addr = a;
    func_din  = din;
    @(negedge cclk);
    func_cen = 1'b1;
    func_wen = 8'hFF;
    if (wen != 8'hFF) begin
      model[a] = (model[a] & wen) | (din & ~wen);
      if (wen == 8'h00) known[a] = 1'b1;
      check("cap_we", 64'(cap_mem_we), 64'h1);
      check("cap_addr", 64'(cap_mem_addr), 64'(a));
      check("cap_data", 64'(cap_mem_wr_data), 64'(din));
    end else begin
      check("cap_we_on_read", 64'(cap_mem_we), 64'h0);
    end
    if (known[a]) check("func_dout", 64'(func_dout), 64'(model[a]));
  endtask

  task automatic idle_cycle();
    logic [7:0] held;
    held = func_dout;
    func_cen = 1'b1;
    func_addr = 9'($urandom_range(0, 511));
    func_wen = 8'($urandom);
    @(negedge cclk);
    func_wen = 8'hFF;
    check("dout_hold_idle", 64'(func_dout), 64'(held));
    check("cap_we_idle", 64'(cap_mem_we), 64'h0);
  endtask

  task automatic run_bist(input bit inject, input bit with_write, input int poke_at,
                          input int reset_at, input bit exp_fail, input logic [8:0] exp_faddr);
    logic [7:0] held;
    int  cnt;
    bit  aborted;
    aborted = 1'b0;
    bist_start = 1'b1;
    if (with_write) begin
      func_cen = 1'b0; func_wen = 8'h00; func_addr = 9'h055; func_din = 8'h6B;
    end
    @(negedge cclk);
    bist_start = 1'b0;
    func_cen = 1'b1;
    func_wen = 8'hFF;
    check("busy_after_start", 64'(bist_busy), 64'h1);
    check("done_cleared", 64'(bist_done), 64'h0);
    check("fail_cleared", 64'(bist_fail), 64'h0);
    if (with_write) begin
      check("start_wr_cap_we", 64'(cap_mem_we), 64'h1);
      check("start_wr_cap_addr", 64'(cap_mem_addr), 64'h055);
      check("start_wr_dout", 64'(func_dout), 64'h6B);
    end
    held = func_dout;
    cnt = 0;
    while (bist_busy && cnt < 4000) begin
      if (cnt == poke_at) dut.mem[9'h0C2] = dut.mem[9'h0C2] | 8'h08;
      if (cnt == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bist_busy), 64'h0);
        check("rst_done", 64'(bist_done), 64'h0);
        check("rst_fail", 64'(bist_fail), 64'h0);
        check("rst_faddr", 64'(bist_fail_addr), 64'h0);
        check("rst_dout", 64'(func_dout), 64'h0);
        check("rst_cap_we", 64'(cap_mem_we), 64'h0);
        check("rst_cap_addr", 64'(cap_mem_addr), 64'h0);
        check("rst_cap_data", 64'(cap_mem_wr_data), 64'h0);
        #2;
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (inject) begin
        func_cen  = 1'b0;
        func_wen  = 8'($urandom);
        func_addr = 9'($urandom_range(0, 511));
        func_din  = 8'($urandom);
        bist_start = (cnt == 500);
      end
      @(negedge cclk);
      cnt++;
      if (inject && (cnt % 256 == 0)) check("dout_hold_busy", 64'(func_dout), 64'(held));
    end
    func_cen = 1'b1;
    func_wen = 8'hFF;
    bist_start = 1'b0;
    if (!aborted) begin
      check("busy_cycles", 64'(cnt), 64'd3073);
      check("bist_done", 64'(bist_done), 64'h1);
      check("bist_fail", 64'(bist_fail), 64'(exp_fail));
      check("bist_fail_addr", 64'(bist_fail_addr), 64'(exp_faddr));
      if (inject) check("dout_after_busy", 64'(func_dout), 64'(held));
      idle_cycle();
      check("done_sticky", 64'(bist_done), 64'h1);
      check("fail_sticky", 64'(bist_fail), 64'(exp_fail));
    end
  endtask

  task automatic random_ops(input int n);
    int op;
    logic [8:0] a;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 3);
      a  = 9'($urandom_range(0, 511));
      case (op)
        0: idle_cycle();
        1: func_access(a, 8'hFF, 8'($urandom));
        2: func_access(a, 8'h00, 8'($urandom));
        default: func_access(a, 8'($urandom), 8'($urandom));
      endcase
    end
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 512; i++) begin
      model[i] = 8'h00;
      known[i] = 1'b0;
    end
    rst_n = 1'b0;
    func_cen = 1'b1; func_wen = 8'hFF; func_addr = '0; func_din = '0; bist_start = 1'b0;
    func_cen2 = 1'b1; func_wen2 = 16'hFFFF; func_addr2 = '0; func_din2 = '0; bist_start2 = 1'b0;
    repeat (3) @(negedge cclk);
    check("reset_busy", 64'(bist_busy), 64'h0);
    check("reset_done", 64'(bist_done), 64'h0);
    check("reset_fail", 64'(bist_fail), 64'h0);
    check("reset_faddr", 64'(bist_fail_addr), 64'h0);
    check("reset_dout", 64'(func_dout), 64'h0);
    check("reset_cap_we", 64'(cap_mem_we), 64'h0);
    check("reset_cap_addr", 64'(cap_mem_addr), 64'h0);
    check("reset_cap_data", 64'(cap_mem_wr_data), 64'h0);
    rst_n = 1'b1;

    // Default write then read-back
    func_access(9'h1A5, 8'h00, 8'h3C);
    func_access(9'h1A5, 8'hFF, 8'h00);
    check("dflt_read", 64'(func_dout), 64'h3C);

    // Partial write: upper nibble protected
    func_access(9'h033, 8'h00, 8'hFF);
    func_access(9'h033, 8'hF0, 8'h00);
    func_access(9'h033, 8'hFF, 8'h00);
    check("partial_read", 64'(func_dout), 64'hF0);

    // Clean BIST with a write in the start cycle and ignored accesses while busy
    run_bist(1'b1, 1'b1, -1, -1, 1'b0, 9'h000);
    model_clear();
    random_ops(300);

    // Injected bit-3 error at 0x0C2 after W0 has passed it
    run_bist(1'b0, 1'b0, 300, -1, 1'b1, 9'h0C2);
    model_clear();
    random_ops(50);

    // Reset mid-test, then a normal run
    run_bist(1'b0, 1'b0, -1, 1000, 1'b0, 9'h000);
    check("abort_no_done", 64'(bist_done), 64'h0);
    run_bist(1'b0, 1'b0, -1, -1, 1'b0, 9'h000);
    model_clear();
    random_ops(100);

    // Small configuration
    bist_start2 = 1'b1;
    @(negedge cclk);
    bist_start2 = 1'b0;
    cnt = 0;
    while (bist_busy2 && cnt < 500) begin
      @(negedge cclk);
      cnt++;
    end
    check("w16_busy_cycles", 64'(cnt), 64'd97);
    check("w16_done", 64'(bist_done2), 64'h1);
    check("w16_fail", 64'(bist_fail2), 64'h0);
    func_cen2 = 1'b0; func_wen2 = 16'h0000; func_addr2 = 4'hF; func_din2 = 16'hA5A5;
    @(negedge cclk);
    check("w16_cap_data", 64'(cap_mem_wr_data2), 64'hA5A5);
    func_wen2 = 16'hFFFF; func_din2 = 16'h0000;
    @(negedge cclk);
    func_cen2 = 1'b1;
    check("w16_read", 64'(func_dout2), 64'hA5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/p405s_icu_parity_array.md
P405S_ICU_PARITY_ARRAY -- requirements
Module: p405s_icu_parity_array

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 9: address width; DEPTH = 2**ADDR_W words.
REQ-003 cclk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 func_cen  in  1  functional chip enable, active-low.
REQ-006 func_wen  in  DATA_W  per-bit write enable, active-low; all ones = read.
REQ-007 func_addr  in  ADDR_W  functional address.
REQ-008 func_din  in  DATA_W  functional write data.
REQ-009 func_dout  out  DATA_W  registered read data.
REQ-010 bist_start  in  1  single-cycle request to run built-in march test.
REQ-011 bist_busy  out  1  BIST owns array.
REQ-012 bist_done  out  1  sticky; test finished.
REQ-013 bist_fail  out  1  sticky; miscompare seen.
REQ-014 bist_fail_addr  out  ADDR_W  address of first miscompare.
REQ-015 cap_mem_we / cap_mem_addr / cap_mem_wr_data  out  1/ADDR_W/DATA_W  shadow capture of post-mux writes.

Function
REQ-016 Array SHALL be DEPTH x DATA_W storage; contents are not reset.
REQ-017 Port mux: bist_busy=1 selects BIST controls; else functional controls.
REQ-018 Access when muxed cen=0: bits with wen[i]=0 written at the edge; func_dout SHALL show mem[addr] one cycle later, write-through (written bits show new data).
REQ-019 func_cen=1 or bist_busy=1: func_dout SHALL hold its last value.
REQ-020 Functional accesses while bist_busy=1 SHALL be ignored: no write, no dout change.
REQ-021 FSM states: IDLE, W0, R0W1, R1W0, R0, DONE.
REQ-022 IDLE->W0 when bist_start=1; this clears bist_done, bist_fail and bist_fail_addr; bist_busy=1 from the next cycle.
REQ-023 W0: write all-zeros, addresses 0..DEPTH-1 ascending, one address per cycle.
REQ-024 R0W1: ascending; per address, read cycle then write-all-ones cycle; expect zeros.
REQ-025 R1W0: descending DEPTH-1..0; read then write-zeros; expect ones.
REQ-026 R0: ascending, one read per cycle; expect zeros.
REQ-027 Compare SHALL occur the cycle after each BIST read. Any bit mismatch sets bist_fail. bist_fail_addr latches only on the first mismatch.
REQ-028 After the final compare, FSM enters DONE: bist_busy=0, bist_done=1, total busy time exactly 6*DEPTH+1 cycles.
REQ-029 DONE->IDLE after one cycle. bist_done and bist_fail stay asserted until the next bist_start or reset.
REQ-030 bist_start while bist_busy=1 SHALL be ignored.
REQ-031 Address counter SHALL wrap only at state boundaries, never mid-state.
REQ-032 Capture: cap_mem_we=1 for exactly one cycle after any muxed write (any wen bit low, cen low). cap_mem_addr and cap_mem_wr_data carry that write's address and muxed data. Otherwise cap_mem_we=0 and the data/address outputs hold.
REQ-033 A simultaneous functional write and bist_start SHALL complete the functional write; BIST starts next cycle.

Reset
REQ-034 rst_n=0 SHALL immediately force: FSM=IDLE, bist_busy/done/fail=0, bist_fail_addr=0, func_dout=0, cap_mem_we=0, cap_mem_addr=0, cap_mem_wr_data=0.
REQ-035 Reset during BIST SHALL abort the test with no done indication. Array contents are then undefined-by-test but not cleared.
REQ-036 Release SHALL be synchronous-deassert safe; the first functional access is accepted on the first edge after rst_n=1.

Verification
REQ-037 Defaults: write addr 0x1A5 data 0x3C all wen=0, then read 0x1A5 -> func_dout=0x3C one cycle after read; cap_mem_we pulse with addr 0x1A5, data 0x3C.
REQ-038 Partial write: preload 0xFF, wen=0xF0 (upper 4 bits disabled), din=0x00 -> read returns 0xF0.
REQ-039 bist_start on a clean array -> bist_busy high 6*512+1=3073 cycles, then bist_done=1, bist_fail=0; functional writes issued during busy leave the array unchanged.
REQ-040 Force mem[0x0C2] bit 3 stuck-at-1 -> bist_fail=1, bist_fail_addr=0x0C2, bist_done=1 after 3073 cycles.
REQ-041 Assert rst_n=0 at busy cycle 1000 -> all outputs 0 immediately; a new bist_start completes normally.
REQ-042 DATA_W=16, ADDR_W=4: BIST busy 97 cycles; write/read of 0xA5A5 at 0xF returns 0xA5A5.
